vga_timing_gen: RTL and testbench

//  Raster timing stage feeding Module_VGADriver and closing its loop to the VGA pins.
//  - Divides clk_in down to the pixel rate.
//  - Generates the 640x480@60 counters current_row/current_line and the active-area enable that the driver consumes.
//  - Registers the driver's color_out onto the RGB pins, with hsync/vsync delayed to match the driver pipeline.

---
 rtl/vga_timing_gen.sv | 135 +++++++++++++
 tb/tb_vga_timing_gen.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing stage for a 640x480@60 VGA path: pixel-rate divider, row/line counters,
// active-area enable, and sync/RGB pin registers aligned to the colour driver's pipeline.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned PIPE_DLY = 2
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [11:0] color_in,
    output logic [9:0]  current_row,
    output logic [9:0]  current_line,
    output logic        enable,
    output logic        pix_tick,
    output logic        frame_start,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        hsync,
    output logic        vsync
);

    localparam int unsigned DIV_W   = $clog2(CLK_DIV);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0]    div_cnt_r;
    logic [9:0]          row_next_s;
    logic [9:0]          line_next_s;
    logic                frame_wrap_s;
    logic                active_s;
    logic                hs_raw_s;
    logic                vs_raw_s;
    logic [PIPE_DLY-1:0] hs_dly_r;
    logic [PIPE_DLY-1:0] vs_dly_r;
    logic [PIPE_DLY-1:0] en_dly_r;

    // Raster decode and next counter values; line/frame wrap happen on the same tick as the row wrap
    always_comb begin
        active_s     = (current_row < H_ACT) && (current_line < V_ACT);
        hs_raw_s     = !((current_row >= HS_START) && (current_row < HS_END));
        vs_raw_s     = !((current_line >= VS_START) && (current_line < VS_END));
        row_next_s   = current_row;
        line_next_s  = current_line;
        frame_wrap_s = 1'b0;
        if (pix_tick) begin
            if (current_row == H_LAST) begin
                row_next_s = 10'd0;
                if (current_line == V_LAST) begin
                    line_next_s  = 10'd0;
                    frame_wrap_s = 1'b1;
                end else begin
                    line_next_s = current_line + 10'd1;
                end
            end else begin
                row_next_s = current_row + 10'd1;
            end
        end else begin
            row_next_s  = current_row;
            line_next_s = current_line;
        end
    end

    // Pixel divider, raster counters, frame strobe and registered active enable
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            div_cnt_r    <= {DIV_W{1'b0}};
            pix_tick     <= 1'b0;
            current_row  <= 10'd0;
            current_line <= 10'd0;
            frame_start  <= 1'b0;
            enable       <= 1'b0;
        end else begin
            if (div_cnt_r == DIV_LAST) begin
                div_cnt_r <= {DIV_W{1'b0}};
            end else begin
                div_cnt_r <= div_cnt_r + DIV_W'(1);
            end
            pix_tick     <= (div_cnt_r == DIV_LAST);
            current_row  <= row_next_s;
            current_line <= line_next_s;
            frame_start  <= frame_wrap_s;
            enable       <= active_s;
        end
    end

    // Delay lines take the raw compare so that syncs and RGB gate share one latency
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            hs_dly_r <= {PIPE_DLY{1'b1}};
            vs_dly_r <= {PIPE_DLY{1'b1}};
            en_dly_r <= {PIPE_DLY{1'b0}};
        end else begin
            hs_dly_r[0] <= hs_raw_s;
            vs_dly_r[0] <= vs_raw_s;
            en_dly_r[0] <= active_s;
            for (int i = 1; i < PIPE_DLY; i++) begin
                hs_dly_r[i] <= hs_dly_r[i-1];
                vs_dly_r[i] <= vs_dly_r[i-1];
                en_dly_r[i] <= en_dly_r[i-1];
            end
        end
    end

    // Pin registers: blank colour outside the delayed active window
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            hsync                 <= 1'b1;
            vsync                 <= 1'b1;
            {vga_r, vga_g, vga_b} <= 12'h000;
        end else begin
            hsync                 <= hs_dly_r[PIPE_DLY-1];
            vsync                 <= vs_dly_r[PIPE_DLY-1];
            {vga_r, vga_g, vga_b} <= en_dly_r[PIPE_DLY-1] ? color_in : 12'h000;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen with a shrunken raster; expected outputs are derived in closed
// form from the number of clocks since reset release, plus a history of driven colours.
module tb_vga_timing_gen;

    localparam int D   = 4;
    localparam int P   = 2;
    localparam int HA  = 20;
    localparam int HFP = 4;
    localparam int HS  = 6;
    localparam int HBP = 5;
    localparam int VA  = 12;
    localparam int VFP = 2;
    localparam int VS  = 2;
    localparam int VBP = 3;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [11:0] color_in;
    logic [9:0]  current_row;
    logic [9:0]  current_line;
    logic        enable;
    logic        pix_tick;
    logic        frame_start;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        hsync;
    logic        vsync;

    int total = 0;
    int bad   = 0;
    int cyc;
    logic [11:0] col_hist [0:8191];
    int hs_low;
    int vs_low;
    int last_fs;
    int fs_count;

    vga_timing_gen #(
        .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .PIPE_DLY(P)
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .color_in(color_in),
        .current_row(current_row), .current_line(current_line), .enable(enable),
        .pix_tick(pix_tick), .frame_start(frame_start),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .hsync(hsync), .vsync(vsync)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_eq(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Pixels advanced after c clocks: first increment at clock D+1, then every D clocks
    function automatic int pix_of(input int c);
        return (c < 1) ? 0 : (c - 1) / D;
    endfunction
    function automatic int ref_row(input int c);
        return pix_of(c) % HT;
    endfunction
    function automatic int ref_line(input int c);
        return (pix_of(c) / HT) % VT;
    endfunction
    function automatic bit ref_active(input int c);
        return (ref_row(c) < HA) && (ref_line(c) < VA);
    endfunction

    task automatic check_all(input int c);
        int exp_hs, exp_vs, exp_rgb, exp_fs, r, l;
        check_eq("row", current_row, ref_row(c));
        check_eq("line", current_line, ref_line(c));
        check_eq("pix_tick", pix_tick, (c > 0 && c % D == 0) ? 1 : 0);
        exp_fs = (c > 1 && (c - 1) % D == 0 && pix_of(c) % (HT * VT) == 0) ? 1 : 0;
        check_eq("frame_start", frame_start, exp_fs);
        check_eq("enable", enable, (c >= 1 && ref_active(c - 1)) ? 1 : 0);
        exp_hs = 1; exp_vs = 1; exp_rgb = 0;
        if (c >= P + 1) begin
            r = ref_row(c - P - 1);
            l = ref_line(c - P - 1);
            exp_hs  = (r >= HA + HFP && r < HA + HFP + HS) ? 0 : 1;
            exp_vs  = (l >= VA + VFP && l < VA + VFP + VS) ? 0 : 1;
            exp_rgb = ref_active(c - P - 1) ? int'(col_hist[c]) : 0;
        end
        check_eq("hsync", hsync, exp_hs);
        check_eq("vsync", vsync, exp_vs);
        check_eq("rgb", {vga_r, vga_g, vga_b}, exp_rgb);
        // Pulse widths and frame period, stated directly in clocks
        if (hsync == 1'b0) hs_low++;
        else if (hs_low > 0) begin
            check_eq("hs_width", hs_low, HS * D);
            hs_low = 0;
        end
        if (vsync == 1'b0) vs_low++;
        else if (vs_low > 0) begin
            check_eq("vs_width", vs_low, VS * HT * D);
            vs_low = 0;
        end
        if (frame_start) begin
            fs_count++;
            if (last_fs >= 0) check_eq("fs_period", c - last_fs, HT * VT * D);
            last_fs = c;
        end
    endtask

    task automatic clear_trackers();
        cyc = 0; hs_low = 0; vs_low = 0; last_fs = -1; fs_count = 0;
    endtask

    // Entered at a negedge; mode 0 random colour, 1 constant red, 2 row-derived colour
    task automatic run(input int n, input int mode);
        logic [3:0] nib;
        for (int k = 0; k < n; k++) begin
            check_all(cyc);
            case (mode)
                0: color_in = 12'($urandom);
                1: color_in = 12'hF00;
                default: begin
                    nib = (cyc >= P) ? 4'(ref_row(cyc - P)) : 4'h0;
                    color_in = {nib, nib, nib};
                end
            endcase
            col_hist[cyc + 1] = color_in;
            @(posedge clk_in);
            cyc++;
            @(negedge clk_in);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_row"}, current_row, 0);
        check_eq({tag, "_line"}, current_line, 0);
        check_eq({tag, "_en"}, enable, 0);
        check_eq({tag, "_tick"}, pix_tick, 0);
        check_eq({tag, "_fs"}, frame_start, 0);
        check_eq({tag, "_hs"}, hsync, 1);
        check_eq({tag, "_vs"}, vsync, 1);
        check_eq({tag, "_rgb"}, {vga_r, vga_g, vga_b}, 0);
    endtask

    task automatic mid_reset_and_release();
        @(posedge clk_in);
        #2;
        rst_n_in = 1'b0;
        #1;
        check_reset_values("async_rst");
        repeat (3) @(negedge clk_in);
        check_reset_values("held_rst");
        clear_trackers();
        rst_n_in = 1'b1;
    endtask

    initial begin
        rst_n_in = 1'b0;
        color_in = 12'h000;
        clear_trackers();
        repeat (4) @(negedge clk_in);
        check_reset_values("por");
        rst_n_in = 1'b1;
        // Two full frames with random colour
        run(2 * HT * VT * D + 80, 0);
        check_eq("fs_count", fs_count, 2);
        mid_reset_and_release();
        run($urandom_range(1500, 2500), 1);
        mid_reset_and_release();
        run(HT * VT * D + 40, 2);
        check_eq("fs_count2", fs_count, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
